// File: rtl/array_order_check_if.sv
// rtl/array_order_check_if.sv - start/result handshake and register-file write bus for array_order_check
//
// Signals
//   go          start request, level-sampled while the checker is idle
//   array       base address of the array to scan
//   length      element count
//   descending  0 = ascending order required, 1 = descending
//   strict      1 = equal neighbours count as an inversion
//   wr_en       register file write enable
//   wr_addr     register file write address
//   wr_data     register file write data
//   busy        high while pairs are being compared
//   done        run complete, results valid
//   sorted      no inversion found in the last run
//   inv_index   offset k of the first inversion, pair (k, k+1)
//   inv_count   number of inversions in the last run
// Modports: master drives requests and writes; slave is the checker.
interface array_order_check_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              go;
    logic [ADDR_W-1:0] array;
    logic [ADDR_W-1:0] length;
    logic              descending;
    logic              strict;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              sorted;
    logic [ADDR_W-1:0] inv_index;
    logic [ADDR_W-1:0] inv_count;

    modport master (
        output go, array, length, descending, strict, wr_en, wr_addr, wr_data,
        input  busy, done, sorted, inv_index, inv_count
    );

    modport slave (
        input  go, array, length, descending, strict, wr_en, wr_addr, wr_data,
        output busy, done, sorted, inv_index, inv_count
    );
endinterface

// File: rtl/array_order_check.sv
// rtl/array_order_check.sv - scans a register-file array for order inversions between neighbours
//
// Ports
//   clock  single clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    array_order_check_if.slave (start request, config, write port, results)
// Parameters
//   DATA_W element width (unsigned), ADDR_W register file address width (depth 2^ADDR_W)
// Configuration
//   ARRAY_ORDER_CHECK_COUNT_ALL_EN defined: scan every pair and count inversions.
//   Undefined: stop at the first inversion.
module array_order_check #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                 clock,
    input logic                 reset,
    array_order_check_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] regs [2**ADDR_W];

    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic              desc_r;
    logic              strict_r;
    logic [ADDR_W-1:0] k;
    logic              short_run;
    logic              done_r;
    logic              sorted_r;
    logic [ADDR_W-1:0] inv_index_r;
    logic [ADDR_W-1:0] inv_count_r;

    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] elem_a, elem_b;
    logic              inversion;
    logic              last_pair;
    logic              early_exit;

    // Contents survive reset; the write lands after this cycle's compare,
    // so a same-cycle read always sees the old word.
    always_ff @(posedge clock) begin
        if (bus.wr_en) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign addr_a = base_r + k;
    assign addr_b = addr_a + ADDR_W'(1);
    assign elem_a = regs[addr_a];
    assign elem_b = regs[addr_b];

    always_comb begin
        inversion = 1'b0;
        case ({desc_r, strict_r})
            2'b00:   inversion = elem_a >  elem_b;
            2'b01:   inversion = elem_a >= elem_b;
            2'b10:   inversion = elem_a <  elem_b;
            default: inversion = elem_a <= elem_b;
        endcase
    end

    // CHECK is only entered with len_r >= 2, so len_r - 2 cannot underflow there.
    assign last_pair = (k == len_r - ADDR_W'(2));

`ifdef ARRAY_ORDER_CHECK_COUNT_ALL_EN
    assign early_exit = 1'b0;
`else
    assign early_exit = inversion;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.go) begin
                    state_nx = (bus.length <= ADDR_W'(1)) ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (last_pair || early_exit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                // A short run publishes its result one edge after accept; hold DONE for that edge.
                if (!short_run && !bus.go) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_r      <= '0;
            len_r       <= '0;
            desc_r      <= 1'b0;
            strict_r    <= 1'b0;
            k           <= '0;
            short_run   <= 1'b0;
            done_r      <= 1'b0;
            sorted_r    <= 1'b0;
            inv_index_r <= '0;
            inv_count_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        base_r      <= bus.array;
                        len_r       <= bus.length;
                        desc_r      <= bus.descending;
                        strict_r    <= bus.strict;
                        k           <= '0;
                        short_run   <= (bus.length <= ADDR_W'(1));
                        done_r      <= 1'b0;
                        sorted_r    <= 1'b0;
                        inv_index_r <= '0;
                        inv_count_r <= '0;
                    end
                end
                CHECK: begin
                    if (inversion) begin
`ifdef ARRAY_ORDER_CHECK_COUNT_ALL_EN
                        if (inv_count_r == '0) begin
                            inv_index_r <= k;
                        end
                        if (inv_count_r != '1) begin
                            inv_count_r <= inv_count_r + ADDR_W'(1);
                        end
`else
                        inv_index_r <= k;
                        inv_count_r <= ADDR_W'(1);
`endif
                    end
                    if (last_pair || early_exit) begin
                        done_r   <= 1'b1;
                        sorted_r <= !inversion && (inv_count_r == '0);
                    end else begin
                        k <= k + ADDR_W'(1);
                    end
                end
                DONE: begin
                    if (short_run) begin
                        short_run <= 1'b0;
                        done_r    <= 1'b1;
                        sorted_r  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == CHECK);
    assign bus.done      = done_r;
    assign bus.sorted    = sorted_r;
    assign bus.inv_index = inv_index_r;
    assign bus.inv_count = inv_count_r;
endmodule

// File: doc/array_order_check.md
ARRAY_ORDER_CHECK -- requirements
Module: array_order_check

Interface
REQ-001 Parameter DATA_W, default 32, element width in bits (unsigned).
REQ-002 Parameter ADDR_W, default 5, internal register file address width; depth = 2^ADDR_W.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port go  input  1  start request, level-sampled in IDLE.
REQ-006 Port array  input  ADDR_W  base address of array, sampled on start accept.
REQ-007 Port length  input  ADDR_W  element count, sampled on start accept.
REQ-008 Port descending  input  1  0 = ascending order required, 1 = descending; sampled on start accept.
REQ-009 Port strict  input  1  1 = equal neighbours count as inversion; sampled on start accept.
REQ-010 Port wr_en / wr_addr / wr_data  input  1 / ADDR_W / DATA_W  register file write port.
REQ-011 Port busy  output  1  high in CHECK.
REQ-012 Port done  output  1  run complete; results valid.
REQ-013 Port sorted  output  1  1 = no inversion found in last run.
REQ-014 Port inv_index  output  ADDR_W  offset k of first inversion, pair (k, k+1).
REQ-015 Port inv_count  output  ADDR_W  number of inversions in last run.

Function
REQ-016 Internal register file SHALL hold 2^ADDR_W words of DATA_W bits, one synchronous write port, two combinational read ports.
REQ-017 FSM states SHALL be IDLE, CHECK, DONE.
REQ-018 IDLE or DONE with go=1 and done=0 path: accept start only in IDLE; DONE SHALL return to IDLE when go=0.
REQ-019 On accept edge SHALL latch array, length, descending, strict; clear done, sorted, inv_index, inv_count; set offset k=0.
REQ-020 If length <= 1 at accept, SHALL go directly to DONE with sorted=1, inv_count=0.
REQ-021 Otherwise SHALL enter CHECK, comparing element (array+k) with (array+k+1) once per cycle.
REQ-022 Inversion: ascending non-strict a>b; ascending strict a>=b; descending non-strict a<b; descending strict a<=b; unsigned compare.
REQ-023 Addresses SHALL wrap modulo 2^ADDR_W.
REQ-024 CHECK SHALL go to DONE after pair k=length-2 or per REQ-033 early exit; else k increments.
REQ-025 Latency: length L >= 2 with no early exit, done SHALL rise L-1 edges after accept edge.
REQ-026 sorted, inv_index, inv_count, done SHALL hold in DONE and IDLE until next accept.
REQ-027 Write to an address being read in same cycle: compare SHALL use pre-write value.
REQ-028 go during CHECK SHALL be ignored; input changes after accept SHALL not affect run.

Reset
REQ-029 reset SHALL force IDLE, done=0, sorted=0, busy=0, inv_index=0, inv_count=0, k=0.
REQ-030 reset mid-CHECK SHALL abort the run; no result asserted.
REQ-031 Register file contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro ARRAY_ORDER_CHECK_COUNT_ALL_EN SHALL select inversion-count mode.
REQ-033 Without macro: CHECK SHALL exit to DONE on first inversion (sorted=0, inv_index=k, inv_count=1).
REQ-034 With macro: CHECK SHALL scan all length-1 pairs, inv_index=first inversion, inv_count=total (saturating at 2^ADDR_W-1).

Verification
REQ-035 r[11..15]=11..15, array=11, length=5, asc non-strict -> done 4 edges after accept, sorted=1, inv_count=0.
REQ-036 r[2..6]={1,2,3,2,5}, array=2, length=5 -> sorted=0, inv_index=2; done 3 edges after accept (no macro), 4 edges with macro, inv_count=1.
REQ-037 r[12..18]={14,12,10,8,6,4,2}, array=12, length=6, descending=1 -> sorted=1; strict=1 with r[13]=14 -> inv_index=0.
REQ-038 r[30]=5, r[31]=6, r[0]=7, array=30, length=3 -> wrap-around, sorted=1; r[0]=4 -> inv_index=1.
REQ-039 length=1 or 0 -> done 1 edge after accept, sorted=1; reset asserted mid-CHECK -> IDLE, done=0, later run correct.
REQ-040 With macro, r[8..14]={5,4,3,2,1,2,3}, array=8, length=7 -> sorted=0, inv_index=0, inv_count=4.
